// File: rtl/lcz80_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lcz80_pkg : shared constants for the Z80 register-transfer engine |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package lcz80_pkg;

   localparam int REG_PAIRS = 8;

   localparam logic [2:0] PAIR_IX = 3'd3;
   localparam logic [2:0] PAIR_IY = 3'd7;

   typedef logic [2:0] xfer_state_t;

   localparam xfer_state_t c_ST_IDLE  = 3'd0;
   localparam xfer_state_t c_ST_SV_RD = 3'd1;
   localparam xfer_state_t c_ST_SV_H  = 3'd2;
   localparam xfer_state_t c_ST_SV_L  = 3'd3;
   localparam xfer_state_t c_ST_LD_H  = 3'd4;
   localparam xfer_state_t c_ST_LD_L  = 3'd5;
   localparam xfer_state_t c_ST_LD_WR = 3'd6;
   localparam xfer_state_t c_ST_DONE  = 3'd7;

endpackage : lcz80_pkg
`default_nettype wire

// File: rtl/lcz80_regxfer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lcz80_regxfer : save/restore of register pairs over byte streams  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lcz80_regxfer
   import lcz80_pkg::*;
#(
   parameter int NUM_PAIRS = REG_PAIRS
)(
   input  logic       clk,
   input  logic       RESET_n,
   input  logic       start_save,
   input  logic       start_load,
   input  logic       abort,
   output logic       busy,
   output logic       done,
   output logic [2:0] rf_addr,
   input  logic [7:0] rf_doh,
   input  logic [7:0] rf_dol,
   output logic [7:0] rf_dih,
   output logic [7:0] rf_dil,
   output logic       rf_weh,
   output logic       rf_wel,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready
);

   localparam logic [2:0] c_LAST = 3'(NUM_PAIRS - 1);

   xfer_state_t r_state;
   xfer_state_t w_state_nxt;
   logic [2:0]  r_idx;
   logic [2:0]  w_idx_nxt;
   logic [7:0]  r_sh_h;
   logic [7:0]  r_sh_l;
   logic [7:0]  w_sh_h_nxt;
   logic [7:0]  w_sh_l_nxt;
   logic        w_busy;
   logic        w_abort;
   logic        w_last;

   assign w_busy  = (r_state != c_ST_IDLE);
   assign w_abort = abort && w_busy;
   assign w_last  = (r_idx == c_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_sh_h_nxt  = r_sh_h;
      w_sh_l_nxt  = r_sh_l;
      case (r_state)
         c_ST_IDLE: begin
            if (start_save) begin
               w_state_nxt = c_ST_SV_RD;
            end else if (start_load) begin
               w_state_nxt = c_ST_LD_H;
            end
         end
         c_ST_SV_RD: begin
            w_sh_h_nxt  = rf_doh;
            w_sh_l_nxt  = rf_dol;
            w_state_nxt = c_ST_SV_H;
         end
         c_ST_SV_H: begin
            if (tx_ready) begin
               w_state_nxt = c_ST_SV_L;
            end
         end
         c_ST_SV_L: begin
            if (tx_ready) begin
               if (w_last) begin
                  w_state_nxt = c_ST_DONE;
               end else begin
                  w_idx_nxt   = r_idx + 3'd1;
                  w_state_nxt = c_ST_SV_RD;
               end
            end
         end
         c_ST_LD_H: begin
            if (rx_valid) begin
               w_sh_h_nxt  = rx_data;
               w_state_nxt = c_ST_LD_L;
            end
         end
         c_ST_LD_L: begin
            if (rx_valid) begin
               w_sh_l_nxt  = rx_data;
               w_state_nxt = c_ST_LD_WR;
            end
         end
         c_ST_LD_WR: begin
            if (w_last) begin
               w_state_nxt = c_ST_DONE;
            end else begin
               w_idx_nxt   = r_idx + 3'd1;
               w_state_nxt = c_ST_LD_H;
            end
         end
         c_ST_DONE: begin
            w_idx_nxt   = 3'd0;
            w_state_nxt = c_ST_IDLE;
         end
         default: begin
            w_idx_nxt   = 3'd0;
            w_state_nxt = c_ST_IDLE;
         end
      endcase
      // Abort overrides any handshake in the same cycle, so nothing is captured.
      if (w_abort) begin
         w_state_nxt = c_ST_IDLE;
         w_idx_nxt   = 3'd0;
         w_sh_h_nxt  = r_sh_h;
         w_sh_l_nxt  = r_sh_l;
      end
   end

   always_ff @(posedge clk or negedge RESET_n) begin
      if (!RESET_n) begin
         r_state <= c_ST_IDLE;
         r_idx   <= 3'd0;
         r_sh_h  <= 8'h00;
         r_sh_l  <= 8'h00;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_sh_h  <= w_sh_h_nxt;
         r_sh_l  <= w_sh_l_nxt;
      end
   end

   assign busy     = w_busy;
   assign done     = (r_state == c_ST_DONE);
   assign rf_addr  = w_busy ? r_idx : 3'd0;
   assign rf_dih   = r_sh_h;
   assign rf_dil   = r_sh_l;
   assign rf_weh   = (r_state == c_ST_LD_WR) && !abort;
   assign rf_wel   = (r_state == c_ST_LD_WR) && !abort;
   assign tx_valid = (r_state == c_ST_SV_H) || (r_state == c_ST_SV_L);
   assign tx_data  = (r_state == c_ST_SV_H) ? r_sh_h :
                     (r_state == c_ST_SV_L) ? r_sh_l : 8'h00;
   assign rx_ready = ((r_state == c_ST_LD_H) || (r_state == c_ST_LD_L)) && !abort;

endmodule : lcz80_regxfer
`default_nettype wire

// File: tb/tb_lcz80_regxfer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_lcz80_regxfer : scoreboard bench for lcz80_regxfer             |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_lcz80_regxfer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance with 8 pairs
   logic       RESET_n = 1'b0;
   logic       start_save = 1'b0, start_load = 1'b0, abort = 1'b0;
   logic       tx_ready = 1'b0, rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       busy, done, rf_weh, rf_wel, tx_valid, rx_ready;
   logic [2:0] rf_addr;
   logic [7:0] rf_doh, rf_dol, rf_dih, rf_dil, tx_data;

   // instance with 2 pairs, save only
   logic       RESET2_n = 1'b0;
   logic       start_save2 = 1'b0, tx_ready2 = 1'b0;
   logic       busy2, done2, rf2_weh, rf2_wel, tx_valid2, rx_ready2;
   logic [2:0] rf2_addr;
   logic [7:0] rf2_doh, rf2_dol, rf2_dih, rf2_dil, tx_data2;

   lcz80_regxfer #(.NUM_PAIRS(8)) u_dut (
      .clk(clk), .RESET_n(RESET_n), .start_save(start_save), .start_load(start_load),
      .abort(abort), .busy(busy), .done(done), .rf_addr(rf_addr),
      .rf_doh(rf_doh), .rf_dol(rf_dol), .rf_dih(rf_dih), .rf_dil(rf_dil),
      .rf_weh(rf_weh), .rf_wel(rf_wel), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
   );

   lcz80_regxfer #(.NUM_PAIRS(2)) u_dut2 (
      .clk(clk), .RESET_n(RESET2_n), .start_save(start_save2), .start_load(1'b0),
      .abort(1'b0), .busy(busy2), .done(done2), .rf_addr(rf2_addr),
      .rf_doh(rf2_doh), .rf_dol(rf2_dol), .rf_dih(rf2_dih), .rf_dil(rf2_dil),
      .rf_weh(rf2_weh), .rf_wel(rf2_wel), .tx_data(tx_data2), .tx_valid(tx_valid2),
      .tx_ready(tx_ready2), .rx_data(8'h00), .rx_valid(1'b0), .rx_ready(rx_ready2)
   );

   // register file behind port A of the 8-pair instance
   logic [15:0] rf [8];
   assign rf_doh = rf[rf_addr][15:8];
   assign rf_dol = rf[rf_addr][7:0];
   always @(posedge clk or negedge RESET_n) begin
      if (!RESET_n) begin
         for (int i = 0; i < 8; i++) rf[i] <= {8'h10 + 8'(i), 8'h20 + 8'(i)};
      end else begin
         if (rf_weh) rf[rf_addr][15:8] <= rf_dih;
         if (rf_wel) rf[rf_addr][7:0]  <= rf_dil;
      end
   end

   assign rf2_doh = 8'h50 + {5'd0, rf2_addr};
   assign rf2_dol = 8'h60 + {5'd0, rf2_addr};

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [7:0]  q_tx[$];
   logic [18:0] q_wr[$];
   logic [7:0]  q_tx2[$];
   logic [15:0] exp_rf [8];
   int          done_cnt = 0, done2_cnt = 0, n_tx2 = 0;
   bit          save_mode = 1'b0;

   // scoreboard monitor, 8-pair instance
   initial begin
      bit         stall_prev;
      logic [7:0] stall_data;
      stall_prev = 1'b0;
      stall_data = 8'h00;
      forever begin
         @(negedge clk);
         if (!RESET_n) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               check("tx_hold_valid", 32'(tx_valid), 32'd1);
               check("tx_hold_data", 32'(tx_data), 32'(stall_data));
            end
            if (tx_valid && tx_ready && !abort) begin
               if (q_tx.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
               else check("tx_byte", 32'(tx_data), 32'(q_tx.pop_front()));
            end
            stall_prev = tx_valid && !tx_ready && !abort;
            stall_data = tx_data;
            if (rf_weh || rf_wel) begin
               check("we_both", 32'({rf_weh, rf_wel}), 32'd3);
               if (q_wr.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
               else check("wr_addr_data", 32'({rf_addr, rf_dih, rf_dil}), 32'(q_wr.pop_front()));
            end
            if (save_mode) check("sv_rx_ready", 32'(rx_ready), 32'd0);
            if (done) done_cnt++;
         end
      end
   end

   // scoreboard monitor, 2-pair instance
   initial begin
      forever begin
         @(negedge clk);
         if (RESET2_n) begin
            if (tx_valid2 && tx_ready2) begin
               n_tx2++;
               if (q_tx2.size() == 0) check("tx2_unexpected", 32'd1, 32'd0);
               else check("tx2_byte", 32'(tx_data2), 32'(q_tx2.pop_front()));
            end
            if (rf2_weh || rf2_wel || rx_ready2) check("sv2_port_idle", 32'd1, 32'd0);
            if (done2) done2_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_save();
      for (int i = 0; i < 8; i++) begin
         q_tx.push_back(exp_rf[i][15:8]);
         q_tx.push_back(exp_rf[i][7:0]);
      end
   endtask

   // runs from posedge+1 and returns at the negedge of the DONE cycle
   task automatic run_until_done(input int budget, input int rdy_mode, input bit second);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < budget; n++) begin
         if (rdy_mode == 1) tx_ready = (n % 3 == 0);
         @(negedge clk);
         if ((second ? done2 : done) === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check("done_seen", 32'(ok), 32'd1);
   endtask

   task automatic feed_byte(input logic [7:0] b, input int gap);
      bit ok;
      ok = 1'b0;
      rx_valid = 1'b0;
      repeat (gap) tick();
      rx_valid = 1'b1;
      rx_data  = b;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (rx_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check("rx_accept", 32'(ok), 32'd1);
      tick();
      rx_valid = 1'b0;
   endtask

   initial begin
      int d0;
      for (int i = 0; i < 8; i++) exp_rf[i] = {8'h10 + 8'(i), 8'h20 + 8'(i)};
      repeat (2) tick();
      RESET_n  = 1'b1;
      RESET2_n = 1'b1;
      @(negedge clk);
      check("rst_busy_done", 32'({busy, done}), 32'd0);
      check("rst_tx", 32'({tx_valid, tx_data}), 32'd0);
      check("rst_rx_ready", 32'(rx_ready), 32'd0);
      check("rst_rf_port", 32'({rf_addr, rf_weh, rf_wel, rf_dih, rf_dil}), 32'd0);
      check("rst2_outputs", 32'({busy2, tx_valid2, rf2_dih, rf2_dil}), 32'd0);

      // save with no backpressure
      tick();
      d0 = done_cnt;
      save_mode = 1'b1;
      tx_ready = 1'b1;
      push_save();
      start_save = 1'b1;
      tick();
      start_save = 1'b0;
      @(negedge clk);
      check("sv_busy_early", 32'({busy, tx_valid}), 32'b10);
      tick();
      @(negedge clk);
      check("sv_first_valid", 32'({tx_valid, tx_data}), 32'h110);
      tick();
      run_until_done(100, 0, 1'b0);
      check("sv_busy_in_done", 32'(busy), 32'd1);
      tick();
      check("sv_queue_empty", 32'(q_tx.size()), 32'd0);
      check("sv_done_count", 32'(done_cnt - d0), 32'd1);
      @(negedge clk);
      check("sv_idle_after", 32'({busy, done, rf_addr}), 32'd0);

      // save with tx_ready asserted one cycle in three
      tick();
      push_save();
      start_save = 1'b1;
      tick();
      start_save = 1'b0;
      run_until_done(200, 1, 1'b0);
      tick();
      tx_ready = 1'b1;
      check("sv3_queue_empty", 32'(q_tx.size()), 32'd0);
      save_mode = 1'b0;

      // load with gaps on rx_valid
      d0 = done_cnt;
      for (int i = 0; i < 8; i++) begin
         exp_rf[i] = {8'hA0 + 8'(i), 8'hB0 + 8'(i)};
         q_wr.push_back({3'(i), exp_rf[i]});
      end
      start_load = 1'b1;
      tick();
      start_load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         feed_byte(exp_rf[i][15:8], i % 3);
         feed_byte(exp_rf[i][7:0], (i + 1) % 3);
      end
      run_until_done(20, 0, 1'b0);
      tick();
      check("ld_writes_all", 32'(q_wr.size()), 32'd0);
      check("ld_done_count", 32'(done_cnt - d0), 32'd1);
      for (int i = 0; i < 8; i++) check("ld_readback", 32'(rf[i]), 32'(exp_rf[i]));

      // simultaneous starts: save wins, later start_load ignored
      save_mode = 1'b1;
      push_save();
      start_save = 1'b1;
      start_load = 1'b1;
      tick();
      start_save = 1'b0;
      start_load = 1'b0;
      repeat (4) tick();
      start_load = 1'b1;
      tick();
      start_load = 1'b0;
      run_until_done(100, 0, 1'b0);
      tick();
      check("both_queue_empty", 32'(q_tx.size()), 32'd0);
      @(negedge clk);
      check("both_idle_after", 32'({busy, rx_ready}), 32'd0);
      save_mode = 1'b0;

      // load aborted between the two bytes of pair 3
      tick();
      d0 = done_cnt;
      for (int i = 0; i < 3; i++) begin
         exp_rf[i] = {8'hC0 + 8'(i), 8'hD0 + 8'(i)};
         q_wr.push_back({3'(i), exp_rf[i]});
      end
      start_load = 1'b1;
      tick();
      start_load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         feed_byte(exp_rf[i][15:8], 1);
         feed_byte(exp_rf[i][7:0], 0);
      end
      feed_byte(8'hC3, 0);
      abort    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'hD3;
      tick();
      abort    = 1'b0;
      rx_valid = 1'b0;
      @(negedge clk);
      check("ab_busy_drop", 32'({busy, rf_weh, rf_wel}), 32'd0);
      repeat (3) tick();
      check("ab_writes", 32'(q_wr.size()), 32'd0);
      check("ab_no_done", 32'(done_cnt - d0), 32'd0);
      for (int i = 0; i < 8; i++) check("ab_readback", 32'(rf[i]), 32'(exp_rf[i]));

      save_mode = 1'b1;
      push_save();
      start_save = 1'b1;
      tick();
      start_save = 1'b0;
      run_until_done(100, 0, 1'b0);
      tick();
      check("ab_save_empty", 32'(q_tx.size()), 32'd0);
      save_mode = 1'b0;

      // two-pair instance: full save, then reset in SV_H, then save again
      d0 = n_tx2;
      tx_ready2 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         q_tx2.push_back(8'h50 + 8'(i));
         q_tx2.push_back(8'h60 + 8'(i));
      end
      start_save2 = 1'b1;
      tick();
      start_save2 = 1'b0;
      run_until_done(50, 0, 1'b1);
      tick();
      check("p2_byte_count", 32'(n_tx2 - d0), 32'd4);
      check("p2_done_count", 32'(done2_cnt), 32'd1);

      tx_ready2 = 1'b0;
      q_tx2.push_back(8'h50);
      start_save2 = 1'b1;
      tick();
      start_save2 = 1'b0;
      tick();
      check("p2_in_sv_h", 32'({busy2, tx_valid2, tx_data2}), 32'h350);
      #2;
      RESET2_n = 1'b0;
      #1;
      check("p2_async_rst", 32'({busy2, tx_valid2, rf2_addr, rf2_weh, rf2_wel}), 32'd0);
      q_tx2.delete();
      tick();
      #2;
      RESET2_n = 1'b1;
      tick();
      d0 = n_tx2;
      tx_ready2 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         q_tx2.push_back(8'h50 + 8'(i));
         q_tx2.push_back(8'h60 + 8'(i));
      end
      start_save2 = 1'b1;
      tick();
      start_save2 = 1'b0;
      run_until_done(50, 0, 1'b1);
      tick();
      check("p2_restart_count", 32'(n_tx2 - d0), 32'd4);
      check("p2_restart_empty", 32'(q_tx2.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_lcz80_regxfer
`default_nettype wire
